// File: rtl/simple_risc_pkg.sv
// Shared types and helpers for the simple RISC memory-side blocks.
// Bus bundles, responder FSM states and the address window check.
package simple_risc_pkg;

   localparam int XLEN  = 32;
   localparam int BYTES = XLEN / 8;

   typedef struct packed {
      logic             we;
      logic [XLEN-1:0]  addr;
      logic [XLEN-1:0]  wdata;
      logic [BYTES-1:0] be;
   } bus_req_t;

   typedef struct packed {
      logic [XLEN-1:0] rdata;
      logic            err;
   } bus_rsp_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } mem_rsp_state_e;

   function automatic logic addr_in_range(
      input logic [63:0] addr,
      input logic [63:0] base,
      input logic [63:0] span
   );
      return (addr >= base) && ((addr - base) < span);
   endfunction

endpackage

// File: rtl/simple_risc_sram.sv
// Single-port synchronous RAM, byte-enable write, registered read.
// Contents are deliberately not reset.
module simple_risc_sram
   import simple_risc_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 1024,
   localparam int AW         = $clog2(DEPTH_WORDS),
   localparam int NB         = DATA_W / 8
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [NB-1:0]     be,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < NB; i++) begin
               if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/simple_risc_mem_responder.sv
// Memory-side responder: one outstanding request, programmable wait,
// RAM access on entry to RESP, response held until handshake.
module simple_risc_mem_responder
   import simple_risc_pkg::*;
#(
   parameter int                DATA_W      = 32,
   parameter int                ADDR_W      = 32,
   parameter int                DEPTH_WORDS = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int                WAIT_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err
);

   localparam int          NB   = DATA_W / 8;
   localparam int          OFF  = $clog2(NB);
   localparam int          AW   = $clog2(DEPTH_WORDS);
   localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) * 64'(NB);

   mem_rsp_state_e    state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [NB-1:0]     be_q;
   logic              err_q;
   logic              rd_q;
   logic [DATA_W-1:0] ram_q;
   logic              accept;
   logic              go_resp;
   logic              acc_err;

   assign accept  = (state_q == IDLE) && req_valid;
   assign go_resp = (state_q == WAIT) && (cnt_q == 4'd0);

   assign acc_err = ((addr_q & ADDR_W'(NB - 1)) != '0) ||
                    !addr_in_range(64'(addr_q), 64'(BASE_ADDR), SPAN);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = WAIT;
               cnt_d   = 4'(WAIT_CYCLES);
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         err_q   <= 1'b0;
         rd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
         end
         if (go_resp) begin
            err_q <= acc_err;
            rd_q  <= !we_q && !acc_err;
         end
      end
   end

   // Base is window-aligned, so the word index is a plain slice.
   simple_risc_sram #(
      .DATA_W      (DATA_W),
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_sram (
      .clk   (clk),
      .en    (go_resp && !acc_err),
      .we    (we_q),
      .be    (be_q),
      .addr  (addr_q[OFF +: AW]),
      .wdata (wdata_q),
      .rdata (ram_q)
   );

   assign req_ready = (state_q == IDLE) && !rst;
   assign rsp_valid = (state_q == RESP);
   assign rsp_err   = rsp_valid && err_q;
   assign rsp_rdata = (rsp_valid && rd_q) ? ram_q : '0;

endmodule
